// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Three-requester arbiter in front of a single SDRAM channel. Each requester
//   posts a one-cycle request that is captured into its own slot. One access is
//   issued at a time. The access completes on sdram_done, or it is abandoned
//   once TIMEOUT_CYCLES WAIT cycles pass without sdram_done.
//
// Ports
//   clk1x, reset               clock, synchronous active-high reset
//   rqN_req/rnw/addr/be/din    request pulse plus fields sampled with it (N = 0..2)
//   rqN_busy/done/dout         pending-or-in-service, completion pulse, read data
//   sdram_ena/rnw/Adr/be/      one-cycle access strobe plus fields that stay held
//     dataWrite                until the access ends
//   sdram_done/dataRead        completion pulse and read data from the channel
//   err_overrun, err_timeout   sticky error flags
//
// state  | meaning
// IDLE   | no access outstanding; pick a winner when any slot is pending
// ISSUE  | sdram_ena high for one cycle with the winner's slot fields
// WAIT   | waiting for sdram_done or for the timeout
module sdram_arbiter #(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter bit PRIO0          = 1'b1
) (
  input  logic        clk1x,
  input  logic        reset,
  input  logic        rq0_req,
  input  logic        rq0_rnw,
  input  logic [26:0] rq0_addr,
  input  logic [3:0]  rq0_be,
  input  logic [31:0] rq0_din,
  output logic        rq0_busy,
  output logic        rq0_done,
  output logic [31:0] rq0_dout,
  input  logic        rq1_req,
  input  logic        rq1_rnw,
  input  logic [26:0] rq1_addr,
  input  logic [3:0]  rq1_be,
  input  logic [31:0] rq1_din,
  output logic        rq1_busy,
  output logic        rq1_done,
  output logic [31:0] rq1_dout,
  input  logic        rq2_req,
  input  logic        rq2_rnw,
  input  logic [26:0] rq2_addr,
  input  logic [3:0]  rq2_be,
  input  logic [31:0] rq2_din,
  output logic        rq2_busy,
  output logic        rq2_done,
  output logic [31:0] rq2_dout,
  output logic        sdram_ena,
  output logic        sdram_rnw,
  output logic [26:0] sdram_Adr,
  output logic [3:0]  sdram_be,
  output logic [31:0] sdram_dataWrite,
  input  logic        sdram_done,
  input  logic [31:0] sdram_dataRead,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e      state_q, state_d;

  logic [2:0]  req_in, rnw_in;
  logic [26:0] addr_in [3];
  logic [3:0]  be_in   [3];
  logic [31:0] din_in  [3];

  logic [2:0]  pending_q;
  logic [1:0]  last_q, gnt_q, win_d;
  logic [2:0]  slot_rnw_q;
  logic [26:0] slot_addr_q [3];
  logic [3:0]  slot_be_q   [3];
  logic [31:0] slot_din_q  [3];

  logic        s_rnw_q;
  logic [26:0] s_adr_q;
  logic [3:0]  s_be_q;
  logic [31:0] s_dw_q;

  logic [2:0]  done_q;
  logic [31:0] dout_q [3];
  logic        err_ovr_q, err_to_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]  busy_o, done_o;

  assign req_in     = {rq2_req, rq1_req, rq0_req};
  assign rnw_in     = {rq2_rnw, rq1_rnw, rq0_rnw};
  assign addr_in[0] = rq0_addr;
  assign addr_in[1] = rq1_addr;
  assign addr_in[2] = rq2_addr;
  assign be_in[0]   = rq0_be;
  assign be_in[1]   = rq1_be;
  assign be_in[2]   = rq2_be;
  assign din_in[0]  = rq0_din;
  assign din_in[1]  = rq1_din;
  assign din_in[2]  = rq2_din;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int off);
    int s;
    s = (int'(base) + off) % 3;
    return s[1:0];
  endfunction

  // Winner selection: requester 0 overrides when PRIO0 is set; otherwise scan
  // cyclically, starting one past the last requester that completed.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    win_d = 2'd0;
    found = 1'b0;
    cand  = 2'd0;
    if (PRIO0 && pending_q[0]) begin
      win_d = 2'd0;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        cand = rr_idx(last_q, i);
        if (!found && pending_q[cand]) begin
          win_d = cand;
          found = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk1x) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. sdram_done outside WAIT has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|pending_q) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (sdram_done || (cnt_q == CNT_MAX)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. Gating with reset keeps the strobes quiet for the whole reset cycle.
  always_comb begin
    sdram_ena = (state_q == S_ISSUE) && !reset;
    busy_o    = (pending_q | done_q) & {3{~reset}};
    done_o    = done_q & {3{~reset}};
  end

  // Datapath: slots, issue registers, completion and error flags
  always_ff @(posedge clk1x) begin
    if (reset) begin
      pending_q <= 3'b000;
      last_q    <= 2'd2;
      gnt_q     <= 2'd0;
      s_rnw_q   <= 1'b1;
      s_adr_q   <= '0;
      s_be_q    <= '0;
      s_dw_q    <= '0;
      done_q    <= 3'b000;
      err_ovr_q <= 1'b0;
      err_to_q  <= 1'b0;
      cnt_q     <= '0;
      for (int n = 0; n < 3; n++) begin
        slot_rnw_q[n]  <= 1'b1;
        slot_addr_q[n] <= '0;
        slot_be_q[n]   <= '0;
        slot_din_q[n]  <= '0;
        dout_q[n]      <= '0;
      end
    end else begin
      done_q <= 3'b000;

      // pending_q clears at the end of the done cycle's predecessor, so a
      // request in the done cycle itself is accepted rather than flagged.
      for (int n = 0; n < 3; n++) begin
        if (req_in[n] && !pending_q[n]) begin
          pending_q[n]   <= 1'b1;
          slot_rnw_q[n]  <= rnw_in[n];
          slot_addr_q[n] <= addr_in[n];
          slot_be_q[n]   <= be_in[n];
          slot_din_q[n]  <= din_in[n];
        end
      end
      if (|(req_in & pending_q)) err_ovr_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            gnt_q   <= win_d;
            s_rnw_q <= slot_rnw_q[win_d];
            s_adr_q <= slot_addr_q[win_d];
            s_be_q  <= slot_be_q[win_d];
            s_dw_q  <= slot_din_q[win_d];
            cnt_q   <= '0;
          end
        end
        S_WAIT: begin
          if (sdram_done) begin
            done_q[gnt_q]    <= 1'b1;
            pending_q[gnt_q] <= 1'b0;
            last_q           <= gnt_q;
            if (s_rnw_q) dout_q[gnt_q] <= sdram_dataRead;
          end else if (cnt_q == CNT_MAX) begin
            done_q[gnt_q]    <= 1'b1;
            pending_q[gnt_q] <= 1'b0;
            dout_q[gnt_q]    <= '0;
            err_to_q         <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rq0_busy        = busy_o[0];
  assign rq1_busy        = busy_o[1];
  assign rq2_busy        = busy_o[2];
  assign rq0_done        = done_o[0];
  assign rq1_done        = done_o[1];
  assign rq2_done        = done_o[2];
  assign rq0_dout        = dout_q[0];
  assign rq1_dout        = dout_q[1];
  assign rq2_dout        = dout_q[2];
  assign sdram_rnw       = s_rnw_q;
  assign sdram_Adr       = s_adr_q;
  assign sdram_be        = s_be_q;
  assign sdram_dataWrite = s_dw_q;
  assign err_overrun     = err_ovr_q;
  assign err_timeout     = err_to_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter. Instance 0 runs with PRIO0=1, instance 1
// with PRIO0=0; both use TIMEOUT_CYCLES=15. Expected accesses go into a
// scoreboard queue when requests are driven and are popped at each sdram_ena.
module tb_sdram_arbiter;

  logic clk1x = 1'b0;
  always #5 clk1x = ~clk1x;

  logic        reset;
  logic        req  [2][3];
  logic        rnw  [2][3];
  logic [26:0] addr [2][3];
  logic [3:0]  be   [2][3];
  logic [31:0] din  [2][3];
  logic        busy [2][3];
  logic        done [2][3];
  logic [31:0] dout [2][3];
  logic        s_ena [2];
  logic        s_rnw [2];
  logic [26:0] s_adr [2];
  logic [3:0]  s_be  [2];
  logic [31:0] s_dw  [2];
  logic        s_done [2];
  logic [31:0] s_dr  [2];
  logic        e_ovr [2];
  logic        e_to  [2];

  typedef struct {
    int          n;
    logic        rnw;
    logic [26:0] addr;
    logic [3:0]  be;
    logic [31:0] din;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_dout [2][3];
  int          n_assert = 0;
  int          n_fail   = 0;

  sdram_arbiter #(.TIMEOUT_CYCLES(15), .PRIO0(1'b1)) dut_p (
    .clk1x(clk1x), .reset(reset),
    .rq0_req(req[0][0]), .rq0_rnw(rnw[0][0]), .rq0_addr(addr[0][0]), .rq0_be(be[0][0]), .rq0_din(din[0][0]),
    .rq0_busy(busy[0][0]), .rq0_done(done[0][0]), .rq0_dout(dout[0][0]),
    .rq1_req(req[0][1]), .rq1_rnw(rnw[0][1]), .rq1_addr(addr[0][1]), .rq1_be(be[0][1]), .rq1_din(din[0][1]),
    .rq1_busy(busy[0][1]), .rq1_done(done[0][1]), .rq1_dout(dout[0][1]),
    .rq2_req(req[0][2]), .rq2_rnw(rnw[0][2]), .rq2_addr(addr[0][2]), .rq2_be(be[0][2]), .rq2_din(din[0][2]),
    .rq2_busy(busy[0][2]), .rq2_done(done[0][2]), .rq2_dout(dout[0][2]),
    .sdram_ena(s_ena[0]), .sdram_rnw(s_rnw[0]), .sdram_Adr(s_adr[0]), .sdram_be(s_be[0]),
    .sdram_dataWrite(s_dw[0]), .sdram_done(s_done[0]), .sdram_dataRead(s_dr[0]),
    .err_overrun(e_ovr[0]), .err_timeout(e_to[0])
  );

  sdram_arbiter #(.TIMEOUT_CYCLES(15), .PRIO0(1'b0)) dut_rr (
    .clk1x(clk1x), .reset(reset),
    .rq0_req(req[1][0]), .rq0_rnw(rnw[1][0]), .rq0_addr(addr[1][0]), .rq0_be(be[1][0]), .rq0_din(din[1][0]),
    .rq0_busy(busy[1][0]), .rq0_done(done[1][0]), .rq0_dout(dout[1][0]),
    .rq1_req(req[1][1]), .rq1_rnw(rnw[1][1]), .rq1_addr(addr[1][1]), .rq1_be(be[1][1]), .rq1_din(din[1][1]),
    .rq1_busy(busy[1][1]), .rq1_done(done[1][1]), .rq1_dout(dout[1][1]),
    .rq2_req(req[1][2]), .rq2_rnw(rnw[1][2]), .rq2_addr(addr[1][2]), .rq2_be(be[1][2]), .rq2_din(din[1][2]),
    .rq2_busy(busy[1][2]), .rq2_done(done[1][2]), .rq2_dout(dout[1][2]),
    .sdram_ena(s_ena[1]), .sdram_rnw(s_rnw[1]), .sdram_Adr(s_adr[1]), .sdram_be(s_be[1]),
    .sdram_dataWrite(s_dw[1]), .sdram_done(s_done[1]), .sdram_dataRead(s_dr[1]),
    .err_overrun(e_ovr[1]), .err_timeout(e_to[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk1x);
    #1;
  endtask

  task automatic issue(input int k, input int n, input logic r, input logic [26:0] a,
                       input logic [3:0] b, input logic [31:0] d, input bit push);
    exp_t e;
    req[k][n]  = 1'b1;
    rnw[k][n]  = r;
    addr[k][n] = a;
    be[k][n]   = b;
    din[k][n]  = d;
    if (push) begin
      e.n = n; e.rnw = r; e.addr = a; e.be = b; e.din = d;
      sb.push_back(e);
    end
  endtask

  task automatic clr_req();
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 3; n++) req[k][n] = 1'b0;
  endtask

  task automatic no_done(input int k, input string tag);
    for (int m = 0; m < 3; m++) chk(tag, 32'(done[k][m]), 32'd0);
  endtask

  // Waits for sdram_ena, checks the issued fields against the scoreboard,
  // answers after lat cycles, then checks the completion cycle. re_n >= 0
  // re-issues a read from that requester in the done cycle.
  task automatic serve(input int k, input int lat, input logic [31:0] rdata, input int exp_wait,
                       input bit spur, input int re_n, input logic [26:0] re_addr);
    exp_t e;
    int   w;
    w = 0;
    while (s_ena[k] !== 1'b1 && w < 30) begin
      cyc();
      w++;
    end
    chk("ena_seen", 32'(s_ena[k]), 32'd1);
    if (exp_wait >= 0) chk("ena_latency", 32'(w), 32'(exp_wait));
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow observed=ena expected=no_access");
      return;
    end
    e = sb.pop_front();
    chk("adr", 32'(s_adr[k]), 32'(e.addr));
    chk("rnw", 32'(s_rnw[k]), 32'(e.rnw));
    chk("be", 32'(s_be[k]), 32'(e.be));
    if (!e.rnw) chk("dw", s_dw[k], e.din);
    if (spur) begin
      s_done[k] = 1'b1;
      cyc();
      s_done[k] = 1'b0;
      chk("ena_one_cycle", 32'(s_ena[k]), 32'd0);
      repeat (lat - 1) cyc();
    end else begin
      repeat (lat) cyc();
    end
    chk("adr_hold", 32'(s_adr[k]), 32'(e.addr));
    no_done(k, "early_done");
    s_done[k] = 1'b1;
    s_dr[k]   = rdata;
    cyc();
    s_done[k] = 1'b0;
    s_dr[k]   = 32'h0BAD0BAD;
    if (e.rnw) exp_dout[k][e.n] = rdata;
    for (int m = 0; m < 3; m++) chk("done_pulse", 32'(done[k][m]), 32'(m == e.n));
    chk("dout", dout[k][e.n], exp_dout[k][e.n]);
    chk("busy_in_done", 32'(busy[k][e.n]), 32'd1);
    if (re_n >= 0) issue(k, re_n, 1'b1, re_addr, 4'hF, 32'd0, 1'b1);
    cyc();
    clr_req();
    chk("done_one_cycle", 32'(done[k][e.n]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic any;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_done[k] = 1'b0;
      s_dr[k]   = 32'h0BAD0BAD;
      for (int n = 0; n < 3; n++) begin
        req[k][n] = 1'b0; rnw[k][n] = 1'b1; addr[k][n] = '0;
        be[k][n] = '0; din[k][n] = '0; exp_dout[k][n] = '0;
      end
    end
    repeat (3) cyc();

    // reset state
    chk("rst_ena", 32'(s_ena[0]), 32'd0);
    chk("rst_rnw", 32'(s_rnw[0]), 32'd1);
    chk("rst_adr", 32'(s_adr[0]), 32'd0);
    chk("rst_dw", s_dw[0], 32'd0);
    chk("rst_busy", 32'({busy[0][2], busy[0][1], busy[0][0]}), 32'd0);
    chk("rst_dout", dout[0][1], 32'd0);
    chk("rst_errs", 32'({e_ovr[0], e_to[0]}), 32'd0);
    reset = 1'b0;
    cyc();

    // single read on rq1, done 5 cycles after ena
    issue(0, 1, 1'b1, 27'h0100000, 4'hF, 32'd0, 1'b1);
    cyc();
    clr_req();
    chk("busy_after_req", 32'(busy[0][1]), 32'd1);
    chk("no_ena_t1", 32'(s_ena[0]), 32'd0);
    cyc();
    serve(0, 5, 32'hDEADBEEF, 0, 1'b0, -1, '0);

    // write on rq2 with a stray sdram_done during ISSUE
    issue(0, 2, 1'b0, 27'h0000200, 4'h3, 32'h12345678, 1'b1);
    cyc();
    clr_req();
    cyc();
    serve(0, 3, 32'h55555555, 0, 1'b1, -1, '0);
    chk("no_overrun_yet", 32'(e_ovr[0]), 32'd0);

    // overrun: second rq2 request with a different address while busy
    issue(0, 2, 1'b1, 27'h0000A10, 4'hF, 32'd0, 1'b1);
    cyc();
    chk("ovr_busy", 32'(busy[0][2]), 32'd1);
    issue(0, 2, 1'b1, 27'h0000B20, 4'hF, 32'd0, 1'b0);
    cyc();
    clr_req();
    chk("err_overrun", 32'(e_ovr[0]), 32'd1);
    serve(0, 2, 32'hA1A1A1A1, 0, 1'b0, -1, '0);

    // priority: make last_grant=0, then rq0 and rq1 together
    issue(0, 0, 1'b1, 27'h0000010, 4'hF, 32'd0, 1'b1);
    cyc();
    clr_req();
    cyc();
    serve(0, 2, 32'h00000010, 0, 1'b0, -1, '0);
    issue(0, 0, 1'b1, 27'h0000020, 4'hF, 32'd0, 1'b1);
    issue(0, 1, 1'b1, 27'h0000030, 4'hF, 32'd0, 1'b1);
    cyc();
    clr_req();
    cyc();
    serve(0, 3, 32'h00000020, 0, 1'b0, 0, 27'h0000040);
    serve(0, 3, 32'h00000030, 0, 1'b0, -1, '0);
    serve(0, 3, 32'h00000040, 0, 1'b0, -1, '0);

    // sdram_done on the timeout cycle: done wins
    issue(0, 2, 1'b1, 27'h0000300, 4'hF, 32'd0, 1'b1);
    cyc();
    clr_req();
    cyc();
    serve(0, 16, 32'hC0C0C0C0, 0, 1'b0, -1, '0);
    chk("coincide_no_timeout", 32'(e_to[0]), 32'd0);

    // timeout on rq0 (its dout currently holds 0x40)
    issue(0, 0, 1'b1, 27'h0000050, 4'hF, 32'd0, 1'b1);
    cyc();
    clr_req();
    cyc();
    chk("to_ena", 32'(s_ena[0]), 32'd1);
    e = sb.pop_front();
    chk("to_adr", 32'(s_adr[0]), 32'(e.addr));
    any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      any = any | done[0][0];
    end
    chk("to_no_early_done", 32'(any), 32'd0);
    cyc();
    exp_dout[0][0] = 32'd0;
    chk("to_done", 32'(done[0][0]), 32'd1);
    chk("to_dout", dout[0][0], exp_dout[0][0]);
    chk("err_timeout", 32'(e_to[0]), 32'd1);
    cyc();
    s_done[0] = 1'b1;
    s_dr[0]   = 32'hFFFFFFFF;
    cyc();
    s_done[0] = 1'b0;
    any = 1'b0;
    repeat (3) begin
      cyc();
      any = any | done[0][0] | done[0][1] | done[0][2];
    end
    chk("late_done_ignored", 32'(any), 32'd0);
    chk("to_busy_clear", 32'(busy[0][0]), 32'd0);
    chk("to_dout_kept", dout[0][0], 32'd0);

    // reset for one cycle during WAIT
    issue(0, 1, 1'b0, 27'h0000060, 4'hF, 32'h66666666, 1'b1);
    cyc();
    clr_req();
    cyc();
    chk("rw_ena", 32'(s_ena[0]), 32'd1);
    e = sb.pop_front();
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 3; n++) exp_dout[k][n] = '0;
    chk("rw_busy_clear", 32'({busy[0][2], busy[0][1], busy[0][0]}), 32'd0);
    chk("rw_errs_clear", 32'({e_ovr[0], e_to[0]}), 32'd0);
    no_done(0, "rw_no_done");
    s_done[0] = 1'b1;
    cyc();
    s_done[0] = 1'b0;
    any = 1'b0;
    repeat (3) begin
      cyc();
      any = any | done[0][0] | done[0][1] | done[0][2] | s_ena[0];
    end
    chk("rw_after_reset_quiet", 32'(any), 32'd0);
    issue(0, 1, 1'b1, 27'h0000070, 4'hF, 32'd0, 1'b1);
    cyc();
    clr_req();
    cyc();
    serve(0, 4, 32'h77777777, 0, 1'b0, -1, '0);

    // round-robin on the PRIO0=0 instance
    issue(1, 0, 1'b1, 27'h0000100, 4'hF, 32'd0, 1'b1);
    issue(1, 1, 1'b1, 27'h0000101, 4'hF, 32'd0, 1'b1);
    issue(1, 2, 1'b1, 27'h0000102, 4'hF, 32'd0, 1'b1);
    cyc();
    clr_req();
    cyc();
    serve(1, 2, 32'h10000000, 0, 1'b0, 0, 27'h0000110);
    serve(1, 2, 32'h10000001, 0, 1'b0, 1, 27'h0000111);
    serve(1, 2, 32'h10000002, 0, 1'b0, 2, 27'h0000112);
    serve(1, 2, 32'h20000000, 0, 1'b0, -1, '0);
    serve(1, 2, 32'h20000001, 0, 1'b0, -1, '0);
    serve(1, 2, 32'h20000002, 0, 1'b0, -1, '0);
    chk("rr_no_overrun", 32'(e_ovr[1]), 32'd0);
    chk("rr_idle", 32'({busy[1][2], busy[1][1], busy[1][0]}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
